octal_stopwatch: RTL and testbench
==================================

OCTAL_STOPWATCH -- requirements
Module: octal_stopwatch

Interface
REQ-001 Parameter TICK_DIV, default 1000000, gives the clock cycles per count tick (100 Hz at 100 MHz); legal range 1..2^24.
REQ-002 Port Clk, input, 1 bit: the single system clock (100 MHz); all state changes on its rising edge.
REQ-003 Port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port StartStop, input, 1 bit: raw asynchronous push-button level; a rising edge toggles run/pause.
REQ-005 Port Clear, input, 1 bit: raw asynchronous push-button level; a rising edge zeroes the count and returns to idle.
REQ-006 Ports BCD6..BCD0, each output, 3 bits: octal count digits, BCD0 least significant; directly drive the seven-digit display driver's digit inputs.
REQ-007 Port Running, output, 1 bit: high while the counter is advancing.
REQ-008 Port Overflow, output, 1 bit: high once the count has saturated at 7777777.

Function
REQ-009 Each of StartStop and Clear SHALL pass through a two-flop synchroniser followed by a history flop; the internal pulse = synchronised level AND NOT history (one cycle wide).
REQ-010 State SHALL update on the 3rd rising Clk edge at which the raw button has been sampled high; holding a button SHALL give exactly one pulse.
REQ-011 The FSM SHALL have states IDLE, RUNNING, PAUSED and OVERFLOW.
REQ-012 In IDLE, a StartStop pulse SHALL move to RUNNING with the prescaler at 0.
REQ-013 In RUNNING, a StartStop pulse SHALL move to PAUSED.
REQ-014 In PAUSED, a StartStop pulse SHALL move to RUNNING.
REQ-015 In RUNNING, a tick with all digits at 7 SHALL move to OVERFLOW.
REQ-016 A Clear pulse in any state SHALL move to IDLE, zero all digits and zero the prescaler on the same edge.
REQ-017 Simultaneous Clear and StartStop pulses: Clear SHALL win; StartStop is discarded.
REQ-018 In OVERFLOW, StartStop SHALL be ignored; only Clear or Reset exits.
REQ-019 The prescaler SHALL count 0..TICK_DIV-1 only in RUNNING and wrap to 0; a tick occurs on the edge where it equals TICK_DIV-1.
REQ-020 In PAUSED the prescaler SHALL hold its value, so a resumed interval continues where it stopped.
REQ-021 With TICK_DIV=1, a tick SHALL occur on every RUNNING cycle.
REQ-022 On a tick, BCD0 SHALL increment by 1; a digit at 7 SHALL wrap to 0 and carry into the next digit in the same cycle (ripple-free, single edge).
REQ-023 A tick at 7777777 SHALL leave all digits at 7 (saturate, no wrap).
REQ-024 A tick coinciding with a StartStop pulse in RUNNING SHALL still apply its increment; the state then becomes PAUSED.
REQ-025 All outputs SHALL be registered.
REQ-026 Running = 1 iff the state is RUNNING.
REQ-027 Overflow = 1 iff the state is OVERFLOW.
REQ-028 Digits SHALL change only on ticks, Clear or Reset.

Reset
REQ-029 Reset low SHALL immediately, without waiting for Clk, force: state IDLE, all BCD digits 0, prescaler 0, Running 0, Overflow 0, and all synchroniser/history flops 0.
REQ-030 A button held high across Reset release SHALL produce exactly one pulse after release.
REQ-031 Reset asserted mid-count SHALL abandon the count; no partial increment is retained.

Verification (TICK_DIV=4)
REQ-032 Reset low then high, no buttons -> digits 0000000, Running 0, Overflow 0, held for 100 cycles.
REQ-033 StartStop pulse, run 40 cycles -> Running 1; BCD0 first increments 4 cycles after entering RUNNING; after 10 ticks the digits read 0000012.
REQ-034 Run 5 ticks, StartStop, wait 50 cycles, StartStop, run 3 ticks -> digits frozen at 0000005 while paused, then 0000010; pause does not lose prescaler phase.
REQ-035 Preload via 2097151 ticks (or TICK_DIV=1) to 7777777, apply 1 more tick -> digits stay 7777777, Overflow 1, Running 0; a subsequent StartStop gives no change.
REQ-036 Clear and StartStop rising on the same cycle while RUNNING -> IDLE, digits 0000000, Running 0.
REQ-037 Assert Reset asynchronously between clock edges while RUNNING at 0000377 -> outputs zero before the next Clk edge.

Source files
------------

// File: rtl/octal_stopwatch.sv
// rtl/octal_stopwatch.sv - seven-digit octal stopwatch with synchronised push-button edges
module octal_stopwatch #(
  parameter int TICK_DIV = 1000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       StartStop,
  input  logic       Clear,
  output logic [2:0] BCD6,
  output logic [2:0] BCD5,
  output logic [2:0] BCD4,
  output logic [2:0] BCD3,
  output logic [2:0] BCD2,
  output logic [2:0] BCD1,
  output logic [2:0] BCD0,
  output logic       Running,
  output logic       Overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUNNING  = 2'd1,
    S_PAUSED   = 2'd2,
    S_OVERFLOW = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          ss_meta, ss_sync, ss_hist;
  logic          clr_meta, clr_sync, clr_hist;
  logic          ss_pulse, clr_pulse;
  logic [PW-1:0] presc;
  logic [20:0]   digits;
  logic [20:0]   digits_inc;
  logic          tick;
  logic          all_seven;
  logic          running_d, overflow_d;

  // Two-flop synchronisers plus a history flop: one-cycle pulse per rising edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ss_meta  <= 1'b0;
      ss_sync  <= 1'b0;
      ss_hist  <= 1'b0;
      clr_meta <= 1'b0;
      clr_sync <= 1'b0;
      clr_hist <= 1'b0;
    end else begin
      ss_meta  <= StartStop;
      ss_sync  <= ss_meta;
      ss_hist  <= ss_sync;
      clr_meta <= Clear;
      clr_sync <= clr_meta;
      clr_hist <= clr_sync;
    end
  end

  assign ss_pulse  = ss_sync & ~ss_hist;
  assign clr_pulse = clr_sync & ~clr_hist;
  assign tick      = (state == S_RUNNING) && (presc == PRESC_MAX);
  assign all_seven = &digits;

  // Carry into digit i exists only when every lower digit is 7.
  always_comb begin
    logic       carry;
    logic [2:0] d;
    carry      = 1'b1;
    digits_inc = '0;
    for (int i = 0; i < 7; i++) begin
      d                   = digits[3*i +: 3];
      digits_inc[3*i +: 3] = d + {2'b00, carry};
      carry               = carry & (d == 3'd7);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      Running  <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state    <= state_next;
      Running  <= running_d;
      Overflow <= overflow_d;
    end
  end

  always_comb begin
    state_next = state;
    if (clr_pulse) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (ss_pulse) state_next = S_RUNNING;
        S_RUNNING: begin
          if (tick && all_seven) state_next = S_OVERFLOW;
          else if (ss_pulse)     state_next = S_PAUSED;
        end
        S_PAUSED:   if (ss_pulse) state_next = S_RUNNING;
        default:    state_next = S_OVERFLOW;
      endcase
    end
  end

  // Flags are decoded from the next state so they line up with the state register.
  always_comb begin
    running_d  = (state_next == S_RUNNING);
    overflow_d = (state_next == S_OVERFLOW);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      presc <= '0;
    end else if (clr_pulse) begin
      presc <= '0;
    end else if (state == S_RUNNING) begin
      presc <= tick ? '0 : presc + PW'(1);
    end else if (state == S_IDLE && ss_pulse) begin
      presc <= '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      digits <= '0;
    end else if (clr_pulse) begin
      digits <= '0;
    end else if (tick && !all_seven) begin
      digits <= digits_inc;
    end
  end

  assign BCD0 = digits[2:0];
  assign BCD1 = digits[5:3];
  assign BCD2 = digits[8:6];
  assign BCD3 = digits[11:9];
  assign BCD4 = digits[14:12];
  assign BCD5 = digits[17:15];
  assign BCD6 = digits[20:18];

endmodule

// File: tb/tb_octal_stopwatch.sv
// tb/tb_octal_stopwatch.sv - randomized and directed checks of octal_stopwatch against an integer count model
module tb_octal_stopwatch;

  localparam int TD   = 4;
  localparam int MAXC = 2097151;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       StartStop = 1'b0;
  logic       Clear = 1'b0;
  logic [2:0] BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0;
  logic       Running, Overflow;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 running, 2 paused, 3 overflow; count is a plain integer.
  int m_count, m_phase, m_mode;
  bit ss_r0, ss_r1, ss_r2, cl_r0, cl_r1, cl_r2;

  octal_stopwatch #(.TICK_DIV(TD)) dut (
    .Clk(Clk), .Reset(Reset), .StartStop(StartStop), .Clear(Clear),
    .BCD6(BCD6), .BCD5(BCD5), .BCD4(BCD4), .BCD3(BCD3),
    .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0),
    .Running(Running), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] dut_digits();
    return {BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};
  endfunction

  task automatic model_reset();
    m_count = 0; m_phase = 0; m_mode = 0;
    ss_r0 = 0; ss_r1 = 0; ss_r2 = 0;
    cl_r0 = 0; cl_r1 = 0; cl_r2 = 0;
  endtask

  // A button edge acts on the edge two samples after it was first seen high.
  task automatic model_edge();
    bit ssp, clp, tk;
    ssp = ss_r1 & ~ss_r2;
    clp = cl_r1 & ~cl_r2;
    if (clp) begin
      m_count = 0; m_phase = 0; m_mode = 0;
    end else begin
      case (m_mode)
        0: if (ssp) begin m_mode = 1; m_phase = 0; end
        1: begin
          tk = (m_phase == TD - 1);
          m_phase = (m_phase + 1) % TD;
          if (tk) begin
            if (m_count == MAXC) m_mode = 3;
            else m_count = m_count + 1;
          end
          if (m_mode == 1 && ssp) m_mode = 2;
        end
        2: if (ssp) m_mode = 1;
        default: ;
      endcase
    end
    ss_r2 = ss_r1; ss_r1 = ss_r0; ss_r0 = StartStop;
    cl_r2 = cl_r1; cl_r1 = cl_r0; cl_r0 = Clear;
  endtask

  task automatic compare_model();
    check("digits", dut_digits(), 32'(m_count));
    check("running", Running, (m_mode == 1));
    check("overflow", Overflow, (m_mode == 3));
  endtask

  task automatic cycle(input logic ss, input logic clr);
    StartStop = ss;
    Clear = clr;
    @(posedge Clk);
    if (!Reset) model_reset();
    else model_edge();
    @(negedge Clk);
    compare_model();
  endtask

  initial begin
    int n;
    logic ss, clr;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_digits", dut_digits(), 0);
    check("rst_running", Running, 0);
    check("rst_overflow", Overflow, 0);
    Reset = 1'b1;
    repeat (100) cycle(0, 0);
    check("idle100", dut_digits(), 0);

    n = 0;
    while (!Running && n < 10) begin cycle(1, 0); n++; end
    check("start_latency", n, 3);
    for (int i = 1; i <= 40; i++) begin
      cycle(0, 0);
      if (i == 3) check("pre_tick", dut_digits(), 0);
      if (i == 4) check("first_tick", dut_digits(), 1);
    end
    check("ten_ticks", dut_digits(), 21'o12);
    check("ten_running", Running, 1);

    repeat (4) cycle(0, 1);
    repeat (2) cycle(0, 0);
    check("cleared", dut_digits(), 0);
    check("cleared_run", Running, 0);

    repeat (3) cycle(1, 0);
    repeat (20) cycle(0, 0);
    check("five_ticks", dut_digits(), 5);
    cycle(1, 0); cycle(0, 0); cycle(0, 0);
    check("paused", Running, 0);
    repeat (50) cycle(0, 0);
    check("paused_hold", dut_digits(), 5);
    cycle(1, 0); cycle(0, 0); cycle(0, 0);
    check("resumed", Running, 1);
    cycle(0, 0);
    check("resume_phase", dut_digits(), 6);
    repeat (8) cycle(0, 0);
    check("after_resume", dut_digits(), 21'o10);

    repeat (4) cycle(1, 1);
    repeat (2) cycle(0, 0);
    check("both_digits", dut_digits(), 0);
    check("both_running", Running, 0);
    check("both_overflow", Overflow, 0);

    repeat (3) cycle(1, 0);
    repeat (2) cycle(0, 0);
    cycle(1, 0); cycle(0, 0); cycle(0, 0);
    check("pre_load_paused", Running, 0);
    dut.digits = 21'o7777776;
    m_count = MAXC - 1;
    cycle(1, 0); cycle(0, 0); cycle(0, 0);
    repeat (12) cycle(0, 0);
    check("ovf_flag", Overflow, 1);
    check("ovf_running", Running, 0);
    check("ovf_digits", dut_digits(), 21'o7777777);
    cycle(1, 0);
    repeat (10) cycle(0, 0);
    check("ovf_ss_ignored", Overflow, 1);
    check("ovf_ss_digits", dut_digits(), 21'o7777777);
    repeat (3) cycle(0, 1);
    cycle(0, 0);
    check("ovf_cleared", Overflow, 0);

    repeat (3) cycle(1, 0);
    n = 0;
    while (m_count != 255 && n < 1500) begin cycle(0, 0); n++; end
    check("reach_377", dut_digits(), 21'o377);
    StartStop = 1'b1;
    #2 Reset = 1'b0;
    #1;
    check("async_digits", dut_digits(), 0);
    check("async_running", Running, 0);
    check("async_overflow", Overflow, 0);
    model_reset();
    repeat (3) cycle(1, 0);
    Reset = 1'b1;
    repeat (10) cycle(1, 0);
    check("held_one_pulse", Running, 1);
    repeat (5) cycle(0, 0);
    check("held_still_run", Running, 1);

    ss = 0; clr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ss = ~ss;
      if (clr) begin
        if ($urandom_range(0, 2) == 0) clr = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        clr = 1'b1;
      end
      if ($urandom_range(0, 999) == 0) begin
        Reset = 1'b0;
        model_reset();
        cycle(ss, clr);
        Reset = 1'b1;
      end else begin
        cycle(ss, clr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
